ysyx_24070016_fetch_unit: RTL and testbench
===========================================

Name: ysyx_24070016_fetch_unit

Overview:
Multi-cycle instruction fetch stage that replaces the single-cycle PC register plus combinational fetch path. It owns the PC, issues word requests to instruction memory over a valid/ready handshake, and holds the returned instruction for the decode stage under a valid/ready handshake. It accepts PC redirects from execute (branch/jump/trap) and squashes any in-flight fetch.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
mem_req_valid  output  1  fetch request valid.
mem_req_ready  input  1  memory accepts request this cycle.
mem_req_addr  output  32  fetch address; equals current pc.
mem_resp_valid  input  1  response data valid.
mem_resp_rdata  input  32  fetched instruction word.
mem_resp_err  input  1  access fault for this response.
inst_valid  output  1  inst/inst_pc valid to decode.
inst_ready  input  1  decode consumes instruction this cycle.
inst  output  32  instruction word.
inst_pc  output  32  PC of inst.
inst_err  output  1  fetch fault flag travelling with inst.
redirect_valid  input  1  redirect PC this cycle.
redirect_pc  input  32  target PC; bits [1:0] ignored.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Encoding is free; one-hot or binary.
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, flush=0, inst=0, inst_pc=0, inst_err=0. While in reset and IDLE: inst_valid=0, mem_req_valid=0.
- Combinational outputs:
  - mem_req_valid = (state==REQ).
  - mem_req_addr = pc.
  - inst_valid = (state==HOLD).
- IDLE: always goes to REQ on the next cycle.
- REQ:
  - mem_req_valid=1.
  - If mem_req_ready=1: go to WAIT. pc_inflight=pc.
  - Otherwise stay in REQ. mem_req_addr must stay stable unless a redirect occurs.
- WAIT, on mem_resp_valid=1:
  - flush=0: latch inst=rdata, inst_pc=pc_inflight, inst_err=mem_resp_err; go to HOLD.
  - flush=1: discard the data, clear flush, go to REQ.
  - Responses that arrive outside WAIT are ignored.
- HOLD:
  - inst_valid=1 and inst/inst_pc/inst_err are stable.
  - On inst_ready=1: pc=pc+4 with 32-bit wrap (32'hFFFFFFFC+4 = 0); go to REQ.
- Redirect (redirect_valid=1) has priority over every handshake in the same cycle. pc={redirect_pc[31:2],2'b00}. Per state:
  - IDLE: stay on the normal path to REQ, using the new pc.
  - REQ without mem_req_ready: stay in REQ; the address switches to the new pc next cycle.
  - REQ with mem_req_ready in the same cycle: the old request is accepted; go to WAIT with flush=1.
  - WAIT: flush=1. If mem_resp_valid arrives the same cycle, discard it and go to REQ with flush=0.
  - HOLD: drop the instruction (inst_ready ignored); go to REQ. Decode never sees the stale instruction after the redirect cycle.
- Minimum latency, with ready and response each arriving one cycle later: REQ, WAIT, HOLD, so inst_valid rises 2 cycles after entering REQ. Steady-state throughput is 1 instruction per 3 cycles.
- Only one outstanding request at a time. A response is never expected in the same cycle as its acceptance.
- Reset asserted mid-operation: all state returns to reset values at that edge, and any outstanding response is ignored afterwards (state≠WAIT).
- inst_err=1 does not stop fetching; execute raises the trap via redirect.

Optional Feature:
Macro YSYX_24070016_FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every HOLD handshake (inst_valid&inst_ready without redirect).
  - perf_stall_cnt increments every cycle in REQ or WAIT.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset then always-ready memory and decode, responses 1 cycle after accept: addresses 80000000, 80000004, 80000008 issued; inst_valid pulses every 3 cycles with inst_pc matching.
2. mem_req_ready held 0 for 4 cycles: mem_req_valid stays 1, addr stays 80000000 and stable; fetch proceeds after ready.
3. inst_ready=0 for 5 cycles in HOLD: inst, inst_pc and inst_err stable, no new request issued; pc advances by 4 only after the handshake.
4. Redirect to 80001002 while in WAIT: the in-flight response (deadbeef) is discarded, the next request is at 80001000, and decode never sees deadbeef.
5. Redirect in the same cycle as the HOLD handshake: the instruction is dropped, and the next fetch uses the redirect target, not pc+4. Also: pc=FFFFFFFC with a handshake yields next addr 00000000.
6. mem_resp_err=1 at pc 80000010: inst_err=1 with inst_pc=80000010; the next fetch at 80000014 has inst_err=0. With the perf macro, counters match the cycle-by-cycle count.

Source files
------------

// File: rtl/ysyx_24070016_fetch_unit.sv
// Multi-cycle instruction fetch: owns the PC, requests words from memory and holds them for decode.
// Optional performance counters are enabled by defining YSYX_24070016_FETCH_PERF_EN.
module ysyx_24070016_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef YSYX_24070016_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_inflight;
    logic        flush;

    logic        req_fire;
    logic        resp_fire;
    logic        deliver;
    logic [31:0] redirect_target;

    assign req_fire        = (state == REQ) && mem_req_ready;
    assign resp_fire       = (state == WAIT) && mem_resp_valid;
    assign deliver         = (state == HOLD) && inst_ready && !redirect_valid;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == HOLD);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            // A redirect or a pending flush turns the response into a refetch.
            WAIT: begin
                if (mem_resp_valid) begin
                    if (flush || redirect_valid) state_next = REQ;
                    else                         state_next = HOLD;
                end
            end
            HOLD: if (redirect_valid || inst_ready) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_inflight <= 32'd0;
            flush       <= 1'b0;
            inst        <= 32'd0;
            inst_pc     <= 32'd0;
            inst_err    <= 1'b0;
        end else begin
            state <= state_next;

            if (redirect_valid)
                pc <= redirect_target;
            else if (deliver)
                pc <= pc + 32'd4;

            if (req_fire)
                pc_inflight <= pc;

            // A request accepted alongside a redirect is already stale when it returns.
            if (req_fire)
                flush <= redirect_valid;
            else if (state == WAIT) begin
                if (mem_resp_valid)
                    flush <= 1'b0;
                else if (redirect_valid)
                    flush <= 1'b1;
            end

            if (resp_fire && !flush && !redirect_valid) begin
                inst     <= mem_resp_rdata;
                inst_pc  <= pc_inflight;
                inst_err <= mem_resp_err;
            end
        end
    end

`ifdef YSYX_24070016_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (deliver)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == REQ) || (state == WAIT))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24070016_fetch_unit.sv
// Randomized bench for the fetch unit, checked every cycle against a transaction-level model
// of the PC, the single outstanding request and the instruction held for decode.
module tb_ysyx_24070016_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef YSYX_24070016_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: booting flag, architectural pc, one outstanding request, one held instruction.
    bit          m_boot = 1'b1;
    logic [31:0] m_pc = RST_PC;
    bit          m_busy = 1'b0;
    logic [31:0] m_out_addr = 32'd0;
    bit          m_stale = 1'b0;
    bit          m_held = 1'b0;
    logic [31:0] m_inst = 32'd0;
    logic [31:0] m_ipc = 32'd0;
    logic        m_ierr = 1'b0;
    logic [31:0] m_fetch = 32'd0;
    logic [31:0] m_stall = 32'd0;

    always #5 clk = ~clk;

    ysyx_24070016_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef YSYX_24070016_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Mode 0: ideal memory/decode; 1: random traffic; 2: hold reset.
    task automatic applyStimulus(input int mode);
        mem_resp_rdata = $urandom;
        redirect_pc    = $urandom;
        case (mode)
            0: begin
                rst            = 1'b0;
                mem_req_ready  = 1'b1;
                mem_resp_valid = m_busy;
                mem_resp_err   = m_busy && (m_out_addr == 32'h80000010);
                inst_ready     = 1'b1;
                redirect_valid = 1'b0;
            end
            1: begin
                rst            = ($urandom_range(0, 299) == 0);
                mem_req_ready  = ($urandom_range(0, 2) != 0);
                mem_resp_valid = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
                mem_resp_err   = ($urandom_range(0, 7) == 0);
                inst_ready     = ($urandom_range(0, 2) != 0);
                redirect_valid = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = {30'h3FFFFFFF, 2'($urandom)};
            end
            default: begin
                rst            = 1'b1;
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                mem_resp_err   = 1'b0;
                inst_ready     = 1'b0;
                redirect_valid = 1'b0;
            end
        endcase
    endtask

    // Advances the model by one clock using the inputs that were present at the edge.
    task automatic updateModel();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        if (rst) begin
            m_boot = 1'b1; m_pc = RST_PC; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
            m_inst = 32'd0; m_ipc = 32'd0; m_ierr = 1'b0; m_fetch = 32'd0; m_stall = 32'd0;
        end else begin
            if (m_held && inst_ready && !redirect_valid) m_fetch = m_fetch + 32'd1;
            if (!m_boot && !m_held) m_stall = m_stall + 32'd1;
            if (m_boot) begin
                m_boot = 1'b0;
                if (redirect_valid) m_pc = tgt;
            end else if (m_held) begin
                if (redirect_valid) begin
                    m_held = 1'b0;
                    m_pc = tgt;
                end else if (inst_ready) begin
                    m_held = 1'b0;
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_busy) begin
                if (mem_resp_valid) begin
                    if (!m_stale && !redirect_valid) begin
                        m_held = 1'b1;
                        m_inst = mem_resp_rdata;
                        m_ipc  = m_out_addr;
                        m_ierr = mem_resp_err;
                    end
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end else if (redirect_valid) begin
                    m_stale = 1'b1;
                end
                if (redirect_valid) m_pc = tgt;
            end else begin
                if (mem_req_ready) begin
                    m_busy     = 1'b1;
                    m_out_addr = m_pc;
                    m_stale    = redirect_valid;
                end
                if (redirect_valid) m_pc = tgt;
            end
        end
    endtask

    task automatic stepCycle(input int mode);
        @(posedge clk);
        updateModel();
        #1;
        checkOutput("req_valid", {31'd0, mem_req_valid}, {31'd0, !m_boot && !m_busy && !m_held});
        checkOutput("req_addr", mem_req_addr, m_pc);
        checkOutput("inst_valid", {31'd0, inst_valid}, {31'd0, m_held});
        checkOutput("inst", inst, m_inst);
        checkOutput("inst_pc", inst_pc, m_ipc);
        checkOutput("inst_err", {31'd0, inst_err}, {31'd0, m_ierr});
`ifdef YSYX_24070016_FETCH_PERF_EN
        checkOutput("perf_fetch", perf_fetch_cnt, m_fetch);
        checkOutput("perf_stall", perf_stall_cnt, m_stall);
`endif
        applyStimulus(mode);
    endtask

    initial begin
        applyStimulus(2);
        $display("[TB] reset");
        repeat (2) stepCycle(2);
        $display("[TB] ideal memory and decode");
        repeat (40) stepCycle(0);
        $display("[TB] randomized traffic");
        for (int i = 0; i < 5000 && bad < 40; i++)
            stepCycle(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
